// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//
// Single-outstanding APB master. A command accepted on the cmd_valid/cmd_ready
// handshake is issued on the bus as SETUP (one cycle) followed by ACCESS. ACCESS
// lasts until the slave raises pready, or until timeoutCycles consecutive
// ACCESS cycles have passed with pready low. In that case the master aborts the
// transfer and reports a timeout. Each transfer ends with a one-cycle response
// pulse on rsp_valid.
//
// Parameters
//   addrWidth     : APB address width
//   dataWidth     : APB data width
//   timeoutCycles : ACCESS cycles with pready low before the transfer is aborted
//
// Ports
//   clk, reset                    : clock (rising edge); asynchronous active-low reset
//   cmd_valid / cmd_ready         : command handshake (ready only while idle)
//   cmd_write, cmd_addr, cmd_wdata: command payload
//   rsp_valid                     : one-cycle completion pulse (no backpressure)
//   rsp_rdata                     : read data (0 for writes and timeouts), held
//                                   until the next completion
//   rsp_err                       : slave error or timeout
//   rsp_timeout                   : transfer aborted by timeout
//   psel, penable, pwrite,
//   paddr, pwdata                 : registered APB request signals
//   prdata, pready, pslverr       : APB slave response signals
// -----------------------------------------------------------------------------
module apb_master #(
    parameter int addrWidth     = 32,
    parameter int dataWidth     = 8,
    parameter int timeoutCycles = 16
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [addrWidth-1:0] cmd_addr,
    input  logic [dataWidth-1:0] cmd_wdata,

    output logic                 rsp_valid,
    output logic [dataWidth-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 rsp_timeout,

    output logic                 psel,
    output logic                 penable,
    output logic                 pwrite,
    output logic [addrWidth-1:0] paddr,
    output logic [dataWidth-1:0] pwdata,
    input  logic [dataWidth-1:0] prdata,
    input  logic                 pready,
    input  logic                 pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Wide enough to hold timeoutCycles itself.
    localparam int CNT_W = (timeoutCycles < 1) ? 1 : $clog2(timeoutCycles + 1);
    // The abort fires on the ACCESS edge that would bring the count to
    // timeoutCycles, i.e. when the count already equals timeoutCycles - 1.
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(timeoutCycles - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    // Ready is a pure decode of the registered state, so it carries no
    // combinational path from cmd_valid.
    assign cmd_ready = (state == IDLE);

    // NOTE: every register here is assigned with <= so that all state updates
    // within this block see the pre-edge values of each other, exactly as flops do.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            // Response flags are pulses: low unless this edge completes a transfer.
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        pwrite  <= cmd_write;
                        paddr   <= cmd_addr;
                        pwdata  <= cmd_wdata;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        state   <= SETUP;
                    end
                end

                SETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end

                ACCESS: begin
                    // pready is tested first so a slave answering on the final
                    // allowed cycle still completes normally.
                    if (pready) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= pslverr;
                        rsp_rdata <= pwrite ? '0 : prdata;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        state     <= IDLE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        wait_cnt    <= wait_cnt + CNT_W'(1);
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
//
// Drives apb_master with directed and random command streams. A slave model
// answers each transfer after a planned number of wait states. A cycle-level
// reference model derives, from each transfer's plan alone, when psel/penable/
// rsp_valid must be high and what the response must carry.
// -----------------------------------------------------------------------------
module tb_apb_master;

    localparam int AW = 32;
    localparam int DW = 8;
    localparam int TO = 16;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;   // ACCESS cycles with pready low before the slave answers
        logic          serr;
        logic [DW-1:0] rdata;
        int            gap;     // idle cycles before this command is presented
    } txn_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    apb_master #(
        .addrWidth    (AW),
        .dataWidth    (DW),
        .timeoutCycles(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    txn_t          cmd_q[$];
    txn_t          cur;
    bit            busy       = 1'b0;
    int            cyc        = 0;
    int            start_cyc  = 0;
    int            acc_len    = 0;
    bit            timed_out  = 1'b0;
    int            gap_left   = 0;
    logic [DW-1:0] exp_rdata  = '0;
    int            n_exp_rsp  = 0;
    int            n_got_rsp  = 0;
    int            acc_seen   = 0;

    function automatic txn_t mk(input logic wr, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input int waits,
                                input logic serr, input logic [DW-1:0] rdata,
                                input int gap);
        txn_t t;
        t.wr = wr; t.addr = addr; t.wdata = wdata; t.waits = waits;
        t.serr = serr; t.rdata = rdata; t.gap = gap;
        return t;
    endfunction

    // One clock cycle: compare DUT outputs with the model, then drive the slave
    // response and the command inputs for the next rising edge.
    task automatic step();
        int   k;
        logic e_psel, e_pen, e_rv, e_ready, e_err, e_to;
        @(posedge clk);
        cyc++;
        @(negedge clk);

        // k = rising edges since the handshake edge: SETUP at 1, ACCESS at
        // 2..acc_len+1, response pulse at acc_len+2.
        k       = busy ? (cyc - start_cyc) : 0;
        e_psel  = busy && k >= 1 && k <= acc_len + 1;
        e_pen   = busy && k >= 2 && k <= acc_len + 1;
        e_rv    = busy && k == acc_len + 2;
        e_ready = !busy || e_rv;
        e_err   = e_rv && (timed_out || cur.serr);
        e_to    = e_rv && timed_out;
        if (e_rv) begin
            exp_rdata = (timed_out || cur.wr) ? '0 : cur.rdata;
            n_exp_rsp++;
            busy = 1'b0;
        end
        if (rsp_valid) n_got_rsp++;

        check("psel", psel, e_psel);
        check("penable", penable, e_pen);
        check("cmd_ready", cmd_ready, e_ready);
        check("rsp_valid", rsp_valid, e_rv);
        check("rsp_err", rsp_err, e_err);
        check("rsp_timeout", rsp_timeout, e_to);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        if (e_psel) begin
            check("paddr", paddr, cur.addr);
            check("pwrite", pwrite, cur.wr);
            check("pwdata", pwdata, cur.wdata);
        end

        // Slave: answer on ACCESS cycle number waits+1, otherwise noise.
        if (psel && penable) acc_seen++;
        else                 acc_seen = 0;
        if (psel && penable && acc_seen > cur.waits) begin
            pready  = 1'b1;
            prdata  = cur.rdata;
            pslverr = cur.serr;
        end else begin
            pready  = (psel && penable) ? 1'b0 : 1'($urandom_range(0, 1));
            prdata  = DW'($urandom);
            pslverr = 1'($urandom_range(0, 1));
        end

        // Command driver.
        if (cmd_q.size() > 0 && gap_left == 0) begin
            cmd_valid = 1'b1;
            cmd_write = cmd_q[0].wr;
            cmd_addr  = cmd_q[0].addr;
            cmd_wdata = cmd_q[0].wdata;
            if (!busy) begin
                cur       = cmd_q.pop_front();
                busy      = 1'b1;
                start_cyc = cyc;
                timed_out = (cur.waits >= TO);
                acc_len   = timed_out ? TO : cur.waits + 1;
                gap_left  = (cmd_q.size() > 0) ? cmd_q[0].gap : 0;
            end
        end else begin
            cmd_valid = 1'b0;
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = AW'($urandom);
            cmd_wdata = DW'($urandom);
            if (!busy && gap_left > 0) gap_left--;
        end
    endtask

    task automatic run_until_idle(input int max_cycles);
        for (int i = 0; i < max_cycles && (busy || cmd_q.size() > 0); i++) step();
        check("drain", (busy || cmd_q.size() != 0), 1'b0);
    endtask

    task automatic check_reset_outputs();
        check("rst_psel", psel, 1'b0);
        check("rst_penable", penable, 1'b0);
        check("rst_pwrite", pwrite, 1'b0);
        check("rst_paddr", paddr, '0);
        check("rst_pwdata", pwdata, '0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_rsp_timeout", rsp_timeout, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   r;
        int   w;
        txn_t t;

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs();
        #2 reset = 1'b1;
        #1 check("post_rst_ready", cmd_ready, 1'b1);

        // Directed: plain write, read with 2 wait states, read timeout,
        // write with slave error, three back-to-back writes.
        cmd_q.push_back(mk(1'b1, 32'd1, 8'd25, 0, 1'b0, 8'h00, 0));
        run_until_idle(50);
        cmd_q.push_back(mk(1'b0, 32'd2, 8'd0, 2, 1'b0, 8'h07, 1));
        run_until_idle(50);
        cmd_q.push_back(mk(1'b0, 32'd3, 8'd0, 1000, 1'b0, 8'h5a, 1));
        run_until_idle(50);
        cmd_q.push_back(mk(1'b1, 32'd4, 8'hc3, 0, 1'b1, 8'h00, 1));
        run_until_idle(50);
        for (int i = 0; i < 3; i++)
            cmd_q.push_back(mk(1'b1, AW'(16 + i), DW'(8'h10 + i), 0, 1'b0, 8'h00, 0));
        run_until_idle(50);

        // Boundary: slave answers on the last allowed ACCESS cycle, then one later.
        cmd_q.push_back(mk(1'b0, 32'h100, 8'h00, TO - 1, 1'b0, 8'ha5, 0));
        cmd_q.push_back(mk(1'b0, 32'h104, 8'h00, TO, 1'b0, 8'h3c, 0));
        run_until_idle(100);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      w = $urandom_range(0, 3);
            else if (r < 9) w = $urandom_range(TO - 2, TO + 1);
            else            w = $urandom_range(TO + 2, 40);
            t = mk(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), w,
                   1'($urandom_range(0, 3) == 0), DW'($urandom), $urandom_range(0, 2));
            cmd_q.push_back(t);
        end
        run_until_idle(3000);

        // Reset in the middle of ACCESS.
        cmd_q.push_back(mk(1'b0, 32'h200, 8'h11, 10, 1'b0, 8'h77, 0));
        repeat (4) step();
        check("mid_access_penable", penable, 1'b1);
        #2 reset = 1'b0;
        cmd_valid = 1'b0;
        #1 check_reset_outputs();
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_rsp_valid", rsp_valid, 1'b0);
            check("rst_hold_psel", psel, 1'b0);
        end
        #2 reset = 1'b1;
        #1 check("rel_ready", cmd_ready, 1'b1);
        check("rel_psel", psel, 1'b0);
        busy      = 1'b0;
        exp_rdata = '0;
        acc_seen  = 0;
        gap_left  = 0;
        cmd_q.delete();

        cmd_q.push_back(mk(1'b0, 32'h300, 8'h00, 1, 1'b0, 8'he1, 0));
        run_until_idle(50);
        step();
        check("rsp_pulse_count", n_got_rsp, n_exp_rsp);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter addrWidth, default 32, meaning APB address width.
REQ-002 SHALL have parameter dataWidth, default 8, meaning APB data width, matching the timer register width.
REQ-003 SHALL have parameter timeoutCycles, default 16, meaning the maximum number of ACCESS cycles with pready low before the master aborts.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high at a clk edge.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  addrWidth  target address.
REQ-010 cmd_wdata  input  dataWidth  write data.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  dataWidth  read data; 0 for writes and timeouts.
REQ-013 rsp_err  output  1  pslverr was sampled high, or the transfer timed out.
REQ-014 rsp_timeout  output  1  the transfer was aborted by timeout.
REQ-015 psel, penable, pwrite  output  1 each  APB control signals.
REQ-016 paddr  output  addrWidth  APB address; pwdata  output  dataWidth  APB write data.
REQ-017 prdata  input  dataWidth; pready  input  1; pslverr  input  1  APB slave response signals.

Function
REQ-018 SHALL implement the FSM states IDLE, SETUP and ACCESS, with all APB outputs registered.
REQ-019 cmd_ready SHALL be high only in IDLE; rsp_valid SHALL have no backpressure.
REQ-020 On handshake in IDLE: latch cmd_write, cmd_addr and cmd_wdata into pwrite, paddr and pwdata, and enter SETUP (psel=1, penable=0) in the next cycle.
REQ-021 SETUP SHALL last exactly 1 cycle, then ACCESS (psel=1, penable=1); paddr, pwrite and pwdata SHALL be held stable throughout SETUP and ACCESS.
REQ-022 At an ACCESS edge with pready=1:
- rsp_rdata = prdata for reads, 0 for writes
- rsp_err = pslverr
- rsp_valid = 1 for the next cycle
- psel = penable = 0
- return to IDLE
REQ-023 Latency: with pready tied high, rsp_valid SHALL assert 3 cycles after the handshake edge; minimum spacing between transfers is 3 cycles.
REQ-024 A wait counter SHALL be cleared on entering ACCESS and SHALL increment on each ACCESS edge with pready=0.
REQ-025 When the wait counter reaches timeoutCycles:
- abort the transfer: rsp_valid = 1, rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0
- drive psel = penable = 0
- return to IDLE
REQ-026 If pready rises on the same edge the counter would reach timeoutCycles, the transfer SHALL complete normally (pready wins).
REQ-027 rsp_valid, rsp_err and rsp_timeout SHALL be low in every cycle other than the completion pulse; rsp_rdata SHALL hold its value until the next completion.
REQ-028 cmd_valid SHALL be ignored outside IDLE; a request held high across a transfer SHALL be accepted on return to IDLE.
REQ-029 The master SHALL NOT interpret the address; an unmapped address with no pready response SHALL end in timeout.

Reset
REQ-030 While reset=0, asynchronously:
- psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout = 0
- paddr, pwdata, rsp_rdata = 0
- wait counter = 0
- state = IDLE
- cmd_ready = 1 after release
REQ-031 Reset asserted mid-SETUP or mid-ACCESS SHALL abort the transfer with no rsp_valid pulse; the first cycle after release SHALL be IDLE.

Verification
REQ-032 Write addr 1, data 25, pready=1 -> psel high 1 cycle after handshake, penable high the following cycle, paddr=1 and pwdata=25 stable, rsp_valid=1 and rsp_err=0 at the 3rd cycle.
REQ-033 Read addr 2, slave returns 8'h07 after 2 wait states -> ACCESS lasts 3 cycles, rsp_rdata=8'h07, rsp_err=0.
REQ-034 Read addr 3, pready never asserted, timeoutCycles=16 -> rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0 after 16 ACCESS cycles; psel low afterwards.
REQ-035 Write with pslverr=1 and pready=1 -> rsp_err=1, rsp_timeout=0.
REQ-036 cmd_valid held high for 3 back-to-back writes -> three transfers, psel low exactly 1 cycle between them, three rsp_valid pulses.
REQ-037 reset pulled low during ACCESS -> all outputs 0 immediately, no rsp_valid; the next command after release completes normally.
